// File: rtl/dly_ctrl_pkg.sv
// dly_ctrl_pkg: shared types, state encodings and timing helper for the tap controller
package dly_ctrl_pkg;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SET = 2'b01, OP_INC = 2'b10, OP_DEC = 2'b11} op_e;
  localparam int TAP_W_DEF = 6;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADJ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  function automatic int step_cost(input int settle);
    return settle + 2;
  endfunction
endpackage

// File: rtl/dly_settle_timer.sv
// dly_settle_timer: loadable down-counter, expired while the count sits at zero
module dly_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (start) cnt <= load;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/dly_tap_ctrl.sv
// dly_tap_ctrl: turns tap commands into ld/adj pulses and closes the loop on tap feedback
module dly_tap_ctrl
  import dly_ctrl_pkg::*;
#(
  parameter int TAP_W      = TAP_W_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int LD_TAP     = 0,
  parameter int MAX_MISS   = 3
) (
  input  logic             clk_i_buf,
  input  logic             rst_n_buf,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [TAP_W-1:0] cmd_tap,
  input  logic [TAP_W-1:0] dly_tap_val_i,
  output logic             dly_ld_o,
  output logic             dly_adj_o,
  output logic             dly_incdec_o,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic             err
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MAX_MISS + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] LD_VAL = TAP_W'(LD_TAP);
  localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISS - 1);
  logic [2:0] state, nxt;
  op_e op_r;
  logic [TAP_W:0] target, new_tgt, fbx;
  logic [TAP_W-1:0] last_fb;
  logic [MW-1:0] miss;
  logic accept, sat_hit, hit, toward, miss_out, expired;
  assign fbx = {1'b0, dly_tap_val_i};
  assign accept = cmd_valid && cmd_ready;
  assign sat_hit = (cmd_op == OP_INC && &dly_tap_val_i) || (cmd_op == OP_DEC && dly_tap_val_i == '0);
  assign new_tgt = cmd_op == OP_SET ? {1'b0, cmd_tap} :
                   cmd_op == OP_INC ? fbx + 1'b1 :
                   cmd_op == OP_DEC ? fbx - 1'b1 : {1'b0, LD_VAL};
  assign hit = fbx == target;
  // movement is judged against the sample taken at the previous check (or at accept)
  assign toward = dly_incdec_o ? dly_tap_val_i > last_fb : dly_tap_val_i < last_fb;
  assign miss_out = !hit && !toward && miss == MISS_LAST;
  dly_settle_timer #(.W(CW)) u_timer (
    .clk     (clk_i_buf),
    .rst_n   (rst_n_buf),
    .start   (state == S_LOAD || state == S_ADJ),
    .load    (SETTLE_LD),
    .expired (expired)
  );
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = !accept ? S_IDLE : cmd_op == OP_LOAD ? S_LOAD :
                     (sat_hit || (cmd_op == OP_SET && cmd_tap == dly_tap_val_i)) ? S_DONE : S_ADJ;
      S_LOAD:  nxt = S_WAIT;
      S_ADJ:   nxt = S_WAIT;
      S_WAIT:  nxt = expired ? S_CHECK : S_WAIT;
      S_CHECK: nxt = (op_r == OP_LOAD || hit || miss_out) ? S_DONE : S_ADJ;
      default: nxt = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk_i_buf or negedge rst_n_buf)
    if (!rst_n_buf) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      dly_ld_o  <= 1'b0;
      dly_adj_o <= 1'b0;
    end else begin
      state     <= nxt;
      cmd_ready <= nxt == S_IDLE;
      busy      <= nxt != S_IDLE;
      done      <= nxt == S_DONE;
      dly_ld_o  <= nxt == S_LOAD;
      dly_adj_o <= nxt == S_ADJ;
    end
  always_ff @(posedge clk_i_buf or negedge rst_n_buf)
    if (!rst_n_buf) begin
      op_r         <= OP_LOAD;
      target       <= '0;
      last_fb      <= '0;
      miss         <= '0;
      dly_incdec_o <= 1'b0;
      sat          <= 1'b0;
      err          <= 1'b0;
    end else if (accept) begin
      op_r         <= op_e'(cmd_op);
      target       <= new_tgt;
      last_fb      <= dly_tap_val_i;
      miss         <= '0;
      dly_incdec_o <= new_tgt > fbx;
      sat          <= sat_hit;
      err          <= 1'b0;
    end else if (state == S_CHECK) begin
      last_fb      <= dly_tap_val_i;
      dly_incdec_o <= target > fbx;
      miss         <= toward ? '0 : miss + 1'b1;
      err          <= op_r == OP_LOAD ? dly_tap_val_i != LD_VAL : miss_out;
    end
endmodule

// File: tb/tb_dly_tap_ctrl.sv
// tb_dly_tap_ctrl: directed tests of the tap controller against a behavioural delay stage
module tb_dly_tap_ctrl;
  import dly_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, set_en = 1'b0, frozen = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_tap = '0, tap = '0, set_val = '0;
  logic cmd_ready, dly_ld, dly_adj, dly_incdec, busy, done, sat, err;
  int checks = 0, errors = 0;
  int done_at, ld_n, adj_n, inc_n, gap_bad, both_hi;
  always #5 clk = ~clk;
  dly_tap_ctrl dut (
    .clk_i_buf     (clk),
    .rst_n_buf     (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_tap       (cmd_tap),
    .dly_tap_val_i (tap),
    .dly_ld_o      (dly_ld),
    .dly_adj_o     (dly_adj),
    .dly_incdec_o  (dly_incdec),
    .busy          (busy),
    .done          (done),
    .sat           (sat),
    .err           (err)
  );
  // delay stage: tap moves on the edge that ends a pulse
  always @(posedge clk)
    if (set_en) tap <= set_val;
    else if (!frozen) begin
      if (dly_ld) tap <= 6'd0;
      else if (dly_adj) tap <= dly_incdec ? tap + 6'd1 : tap - 6'd1;
    end
  task automatic set_tap(input logic [5:0] v);
    @(negedge clk); set_val = v; set_en = 1'b1;
    @(negedge clk); set_en = 1'b0;
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] t);
    int prev;
    prev = -100; ld_n = 0; adj_n = 0; inc_n = 0; gap_bad = 0; both_hi = 0; done_at = -1;
    @(negedge clk); cmd_valid = 1'b1; cmd_op = op; cmd_tap = t;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (dly_ld && dly_adj) both_hi++;
      if (dly_ld) ld_n++;
      if (dly_adj) begin
        adj_n++;
        if (dly_incdec) inc_n++;
        if (prev >= 0 && n - prev != 4) gap_bad++;
        prev = n;
      end
      if (done) begin done_at = n; break; end
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    checks++; if ({busy, done, dly_ld, dly_adj, sat, err} !== 6'b0) begin errors++; $display("FAIL rst_outs got %b exp 000000", {busy, done, dly_ld, dly_adj, sat, err}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready, busy, dly_ld, dly_adj} !== 4'b1000) begin errors++; $display("FAIL post_rst got %b exp 1000", {cmd_ready, busy, dly_ld, dly_adj}); end
    set_tap(6'd0);
    @(negedge clk); cmd_valid = 1'b1; cmd_op = OP_SET; cmd_tap = 6'd5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_ready, busy, dly_adj, done} !== 4'b1000) begin errors++; $display("FAIL abort got %b exp 1000", {cmd_ready, busy, dly_adj, done}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL abort_idle got %b exp 10", {cmd_ready, busy}); end
  endtask
  task automatic test_load;
    set_tap(6'd17);
    run_cmd(OP_LOAD, 6'd0);
    checks++; if (ld_n != 1) begin errors++; $display("FAIL load_pulses got %0d exp 1", ld_n); end
    checks++; if (adj_n != 0) begin errors++; $display("FAIL load_adj got %0d exp 0", adj_n); end
    checks++; if (done_at != 4) begin errors++; $display("FAIL load_done got %0d exp 4", done_at); end
    checks++; if (tap !== 6'd0) begin errors++; $display("FAIL load_tap got %0d exp 0", tap); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", err); end
  endtask
  task automatic test_set_up;
    set_tap(6'd0);
    run_cmd(OP_SET, 6'd5);
    checks++; if (adj_n != 5) begin errors++; $display("FAIL up_pulses got %0d exp 5", adj_n); end
    checks++; if (inc_n != 5) begin errors++; $display("FAIL up_incdec got %0d exp 5", inc_n); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL up_spacing got %0d exp 0", gap_bad); end
    checks++; if (done_at != 20) begin errors++; $display("FAIL up_done got %0d exp 20", done_at); end
    checks++; if (tap !== 6'd5) begin errors++; $display("FAIL up_tap got %0d exp 5", tap); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL up_done_busy got %b%b exp 10", busy, cmd_ready); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL up_ready got %b%b exp 10", cmd_ready, busy); end
  endtask
  task automatic test_set_down;
    set_tap(6'd40);
    run_cmd(OP_SET, 6'd38);
    checks++; if (adj_n != 2) begin errors++; $display("FAIL dn_pulses got %0d exp 2", adj_n); end
    checks++; if (inc_n != 0) begin errors++; $display("FAIL dn_incdec got %0d exp 0", inc_n); end
    checks++; if (done_at != 8) begin errors++; $display("FAIL dn_done got %0d exp 8", done_at); end
    checks++; if (tap !== 6'd38) begin errors++; $display("FAIL dn_tap got %0d exp 38", tap); end
    run_cmd(OP_SET, 6'd38);
    checks++; if (done_at != 0) begin errors++; $display("FAIL same_done got %0d exp 0", done_at); end
    checks++; if (adj_n + ld_n != 0) begin errors++; $display("FAIL same_pulses got %0d exp 0", adj_n + ld_n); end
  endtask
  task automatic test_sat;
    set_tap(6'd63);
    run_cmd(OP_INC, 6'd0);
    checks++; if (done_at != 0 || adj_n != 0) begin errors++; $display("FAIL inc_sat_seq got done %0d adj %0d exp 0 0", done_at, adj_n); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL inc_sat got %b exp 1", sat); end
    set_tap(6'd0);
    run_cmd(OP_DEC, 6'd0);
    checks++; if (done_at != 0 || adj_n != 0) begin errors++; $display("FAIL dec_sat_seq got done %0d adj %0d exp 0 0", done_at, adj_n); end
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL dec_sat got %b exp 1", sat); end
    run_cmd(OP_INC, 6'd0);
    checks++; if (sat !== 1'b0 || tap !== 6'd1 || done_at != 4) begin errors++; $display("FAIL inc_clr got sat %b tap %0d done %0d exp 0 1 4", sat, tap, done_at); end
  endtask
  task automatic test_frozen;
    set_tap(6'd10);
    frozen = 1'b1;
    run_cmd(OP_SET, 6'd12);
    checks++; if (adj_n != 3) begin errors++; $display("FAIL frz_pulses got %0d exp 3", adj_n); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL frz_err got %b exp 1", err); end
    checks++; if (done_at != 12) begin errors++; $display("FAIL frz_done got %0d exp 12", done_at); end
    frozen = 1'b0;
    run_cmd(OP_DEC, 6'd0);
    checks++; if (err !== 1'b0 || tap !== 6'd9) begin errors++; $display("FAIL frz_clr got err %b tap %0d exp 0 9", err, tap); end
  endtask
  task automatic test_soak;
    logic [1:0] op;
    logic [5:0] t, exp_tap;
    logic exp_sat;
    int exp_done;
    set_tap(6'd20);
    exp_tap = 6'd20;
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(3));
      t = 6'($urandom_range(63));
      exp_sat = 1'b0;
      exp_done = 4;
      case (op)
        OP_LOAD: exp_tap = 6'd0;
        OP_SET: begin exp_done = 4 * (t > exp_tap ? int'(t - exp_tap) : int'(exp_tap - t)); exp_tap = t; end
        OP_INC: if (exp_tap == 6'd63) begin exp_sat = 1'b1; exp_done = 0; end else exp_tap = exp_tap + 6'd1;
        default: if (exp_tap == 6'd0) begin exp_sat = 1'b1; exp_done = 0; end else exp_tap = exp_tap - 6'd1;
      endcase
      run_cmd(op, t);
      checks++; if (tap !== exp_tap) begin errors++; $display("FAIL soak_tap #%0d op %0d got %0d exp %0d", i, op, tap, exp_tap); end
      checks++; if (done_at != exp_done) begin errors++; $display("FAIL soak_done #%0d op %0d got %0d exp %0d", i, op, done_at, exp_done); end
      checks++; if (sat !== exp_sat || err !== 1'b0) begin errors++; $display("FAIL soak_flags #%0d got sat %b err %b exp %b 0", i, sat, err, exp_sat); end
      checks++; if (both_hi != 0) begin errors++; $display("FAIL soak_overlap #%0d got %0d exp 0", i, both_hi); end
    end
  endtask
  initial begin
    test_reset;
    test_load;
    test_set_up;
    test_set_down;
    test_sat;
    test_frozen;
    test_soak;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
